// File: rtl/kernel_load_sequencer.sv
// kernel_load_sequencer
// Write-side sequencer for the kernel buffer. Accepts a valid/ready stream of
// weights and turns each accepted beat into a registered buffer write.
// Nested element/filter wrap counters produce the write address. The sequencer
// flags each completed kernel and holds a completion flag until the
// controller acknowledges it.
module kernel_load_sequencer #(
  parameter int K           = 3,
  parameter int NUM_FILTERS = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       elem_idx,
  output logic [31:0]       filter_idx,
  output logic              kernel_done,
  output logic              load_done,
  input  logic              done_ack,
  output logic              busy
);

  localparam int          KK        = K * K;
  localparam logic [31:0] ELEM_LAST = 32'(KK - 1);
  localparam logic [31:0] FILT_LAST = 32'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [31:0]         r_elem_idx;
  logic [31:0]         r_filter_idx;
  logic                r_wr_en_p1;
  logic [ADDR_W-1:0]   r_wr_addr_p1;
  logic [DATA_W-1:0]   r_wr_data_p1;
  logic                r_kernel_done_p1;

  logic                w_xfer;
  logic                w_elem_last;
  logic                w_filt_last;
  logic [ADDR_W-1:0]   w_addr;

  // Handshake and address for the beat currently offered (stage p0)
  assign w_xfer      = (r_state == S_LOAD) && in_valid;
  assign w_elem_last = (r_elem_idx == ELEM_LAST);
  assign w_filt_last = (r_filter_idx == FILT_LAST);
  // Address uses the pre-increment counters; upper bits are dropped because
  // the buffer is sized so the full load always fits in ADDR_W bits.
  assign w_addr      = ADDR_W'(r_filter_idx * 32'(KK) + r_elem_idx);

  // Sequencer FSM: counters, state and the registered write port (stage p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_elem_idx       <= '0;
      r_filter_idx     <= '0;
      r_wr_en_p1       <= 1'b0;
      r_wr_addr_p1     <= '0;
      r_wr_data_p1     <= '0;
      r_kernel_done_p1 <= 1'b0;
    end else begin
      r_wr_en_p1       <= 1'b0;
      r_kernel_done_p1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_LOAD;
            r_elem_idx   <= '0;
            r_filter_idx <= '0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_wr_en_p1   <= 1'b1;
            r_wr_addr_p1 <= w_addr;
            r_wr_data_p1 <= in_data;
            if (w_elem_last) begin
              r_elem_idx       <= '0;
              r_kernel_done_p1 <= 1'b1;
              if (w_filt_last) begin
                // Final element: both counters wrap and ready drops next cycle
                r_filter_idx <= '0;
                r_state      <= S_DONE;
              end else begin
                r_filter_idx <= r_filter_idx + 32'd1;
              end
            end else begin
              r_elem_idx <= r_elem_idx + 32'd1;
            end
          end
        end
        S_DONE: begin
          // A start arriving with the acknowledge is dropped on purpose; the
          // controller must issue a fresh start from IDLE.
          if (done_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode directly from the state register
  assign in_ready    = (r_state == S_LOAD);
  assign busy        = (r_state != S_IDLE);
  assign load_done   = (r_state == S_DONE);

  assign wr_en       = r_wr_en_p1;
  assign wr_addr     = r_wr_addr_p1;
  assign wr_data     = r_wr_data_p1;
  assign kernel_done = r_kernel_done_p1;
  assign elem_idx    = r_elem_idx;
  assign filter_idx  = r_filter_idx;

endmodule

// File: tb/tb_kernel_load_sequencer.sv
// Testbench for kernel_load_sequencer: randomized stimulus, a transaction-level
// reference model and a scoreboard monitor sampling on the falling edge.
module tb_kernel_load_sequencer;

  localparam int K     = 3;
  localparam int NF    = 2;
  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int KK    = K * K;
  localparam int TOTAL = KK * NF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          done_ack = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [31:0]   elem_idx;
  logic [31:0]   filter_idx;
  logic          kernel_done;
  logic          load_done;
  logic          busy;

  always #5 clk = ~clk;

  kernel_load_sequencer #(
    .K(K), .NUM_FILTERS(NF), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .elem_idx(elem_idx),
    .filter_idx(filter_idx), .kernel_done(kernel_done),
    .load_done(load_done), .done_ack(done_ack), .busy(busy)
  );

  typedef struct {
    int unsigned   addr;
    logic [DW-1:0] data;
    logic          kd;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_vec = 0;
  int   n_fail = 0;
  // Reference model: 0 = idle, 1 = loading, 2 = complete; m_n = beats taken
  int   m_st = 0;
  int   m_n = 0;
  bit   m_rst_edge = 1'b0;
  bit   mon_on = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model reaction to one clock edge, computed from the beat count alone
  function automatic void model_edge(input logic s, input logic v, input logic a,
                                     input logic r, input logic [DW-1:0] d);
    exp_t e;
    m_rst_edge = r;
    if (r) begin
      m_st = 0;
      m_n  = 0;
    end else if (m_st == 0) begin
      if (s) begin
        m_st = 1;
        m_n  = 0;
      end
    end else if (m_st == 1) begin
      if (v) begin
        e.addr = m_n;
        e.data = d;
        e.kd   = ((m_n % KK) == KK - 1);
        q.push_back(e);
        m_n++;
        if (m_n == TOTAL) begin
          m_st = 2;
          m_n  = 0;
        end
      end
    end else begin
      if (a) m_st = 0;
    end
  endfunction

  task automatic step(input logic s, input logic v, input logic a,
                      input logic r, input logic [DW-1:0] d);
    start    = s;
    in_valid = v;
    done_ack = a;
    rst      = r;
    in_data  = d;
    @(posedge clk);
    model_edge(s, v, a, r, d);
    #1;
  endtask

  // Drive beats until the model reports completion. mode 0: valid always,
  // sequential data 1..N; mode 1: valid toggles; mode 2: random valid/data.
  // A stray start is injected part way through and must be ignored.
  task automatic run_load(input int mode);
    int guard;
    logic v;
    logic [DW-1:0] d;
    guard = 0;
    while (m_st == 1 && guard < 300) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (guard % 2 == 0);
      else v = ($urandom_range(0, 2) != 0);
      d = (mode == 0) ? DW'(m_n + 1) : DW'($urandom);
      step(guard == 4, v, 1'b0, 1'b0, d);
      guard++;
    end
    n_vec++;
    if (m_st != 2) begin
      n_fail++;
      $display("FAIL load_complete: model state %0d after %0d cycles, required 2", m_st, guard);
    end
  endtask

  // Scoreboard monitor: compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (mon_on) begin
      chk("in_ready",   32'(in_ready),  32'(m_st == 1));
      chk("busy",       32'(busy),      32'(m_st != 0));
      chk("load_done",  32'(load_done), 32'(m_st == 2));
      chk("elem_idx",   elem_idx,       32'(m_n % KK));
      chk("filter_idx", filter_idx,     32'(m_n / KK));
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("wr_en",       32'(wr_en),       32'd1);
        chk("wr_addr",     32'(wr_addr),     me.addr);
        chk("wr_data",     32'(wr_data),     32'(me.data));
        chk("kernel_done", 32'(kernel_done), 32'(me.kd));
      end else begin
        chk("wr_en_idle",       32'(wr_en),       32'd0);
        chk("kernel_done_idle", 32'(kernel_done), 32'd0);
        if (m_rst_edge) begin
          chk("wr_addr_rst", 32'(wr_addr), 32'd0);
          chk("wr_data_rst", 32'(wr_data), 32'd0);
        end
      end
    end
  end

  initial begin
    // Reset
    step(0, 0, 0, 1, 0);
    mon_on = 1'b1;
    step(0, 1, 1, 1, 8'h55);
    step(0, 1, 0, 0, 8'h11);

    // Basic load, in_valid held high, data 1..18
    step(1, 1, 0, 0, 8'd1);
    run_load(0);

    // Hold in DONE without acknowledge; stray start must be ignored
    for (int i = 0; i < 10; i++) step(i == 3, 1'b1, 1'b0, 1'b0, DW'($urandom));
    // Acknowledge together with start: back to IDLE only
    step(1, 1, 1, 0, DW'($urandom));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, DW'($urandom));

    // Back-pressure load with toggling valid
    step(1, 0, 0, 0, 0);
    run_load(1);
    step(0, 0, 1, 0, 0);

    // Reset after five accepted beats, then reload from address 0
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 50 && m_n < 5; i++) step(0, $urandom_range(0, 1) == 1, 0, 0, DW'($urandom));
    step(0, 1, 0, 1, DW'($urandom));
    step(0, 1, 0, 0, DW'($urandom));
    step(1, 0, 0, 0, 0);
    run_load(2);
    step(0, 0, 1, 0, 0);

    // Restart: back-to-back full load after acknowledge
    step(1, 1, 0, 0, 8'd1);
    run_load(0);
    step(0, 0, 1, 0, 0);

    // Fully random control traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0, DW'($urandom));
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/kernel_load_sequencer.md
Name: kernel_load_sequencer

Overview:
- Write-side partner of the kernel/window counters. It accepts a valid/ready stream of kernel weights and generates write enable, address and data for the kernel buffer.
- Tracks element and filter position with nested wrap counters. Flags each completed kernel and completion of the whole load.
- Sits between the weight input port and the kernel buffer. The convolution controller starts it and acknowledges completion.

Parameters:
- K, 3, kernel side length; one kernel is K*K elements.
- NUM_FILTERS, 4, number of kernels loaded per start.
- DATA_W, 8, weight width in bits.
- ADDR_W, 16, kernel buffer address width; must satisfy 2^ADDR_W >= K*K*NUM_FILTERS.

Ports:
- clk, input, 1, clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a load; sampled only in IDLE.
- in_valid, input, 1, weight stream valid.
- in_data, input, DATA_W, weight stream data.
- in_ready, output, 1, sequencer can accept a beat.
- wr_en, output, 1, kernel buffer write strobe (registered).
- wr_addr, output, ADDR_W, kernel buffer write address (registered).
- wr_data, output, DATA_W, kernel buffer write data (registered).
- elem_idx, output, 32, current element counter, 0..K*K-1.
- filter_idx, output, 32, current filter counter, 0..NUM_FILTERS-1.
- kernel_done, output, 1, one-cycle pulse coincident with the write of each kernel's last element.
- load_done, output, 1, high while in DONE state.
- done_ack, input, 1, controller acknowledges load_done.
- busy, output, 1, high in LOAD or DONE.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On rst in any state, mid-load included:
  - state returns to IDLE;
  - elem_idx, filter_idx, wr_en, wr_addr, wr_data, kernel_done, load_done, busy and in_ready are all 0;
  - any partially loaded kernel is abandoned.
- Reset has priority over every other input.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> LOAD next cycle; elem_idx and filter_idx are cleared to 0.
- LOAD:
  - in_ready=1, driven combinationally from state.
  - A transfer occurs when in_valid && in_ready.
  - On a transfer, on the next edge:
    - wr_en<=1;
    - wr_data<=in_data;
    - wr_addr<=filter_idx*K*K+elem_idx (pre-increment values, truncated to ADDR_W).
  - Write latency is 1 cycle after the accepting edge. With no transfer, wr_en<=0.
- Counters advance only on a transfer:
  - elem_idx wraps from K*K-1 to 0;
  - on that wrap, filter_idx increments;
  - on a transfer with elem_idx==K*K-1, kernel_done<=1 for exactly one cycle, aligned with wr_en.
- Last element: a transfer with elem_idx==K*K-1 and filter_idx==NUM_FILTERS-1:
  - the write is issued;
  - both counters wrap to 0;
  - state -> DONE.
  - in_ready is therefore 0 from the following cycle, so no extra beat is accepted.
- DONE:
  - load_done=1, in_ready=0, busy=1; wr_en=0 after the final write cycle.
  - done_ack=1 -> IDLE.
- Simultaneous events:
  - start in LOAD or DONE is ignored;
  - start together with done_ack in DONE -> IDLE only; start must be re-asserted.
  - done_ack outside DONE is ignored.
- Stalls: in_valid low in LOAD holds the counters with no writes. No timeout.
- Back-to-back: in_valid held high gives one write per cycle; a full load takes K*K*NUM_FILTERS consecutive cycles.

Test Plan:
- Use K=3, NUM_FILTERS=2, in_valid=1 continuously.
- Basic load: rst, start pulse, in_data=1..18 -> wr_en high for 18 consecutive cycles starting 1 cycle after the first accept, wr_addr 0..17, wr_data 1..18; kernel_done pulses with addr 8 and addr 17; load_done=1 after the last write; in_ready=0 in DONE.
- Back-pressure: in_valid toggled 1,0,1,0 -> writes only on accepted beats, addresses contiguous, no duplicates; elem_idx holds during the gaps.
- Reset mid-load: rst after 5 accepted beats -> all outputs 0 next cycle, state IDLE; a new start reloads from wr_addr 0.
- Ignored start: start pulsed during LOAD and during DONE -> no counter clear, no state change.
- Completion handshake: hold done_ack=0 for 10 cycles -> load_done stays 1 and in_ready stays 0. Assert done_ack together with start -> IDLE with load_done=0 and busy=0; no new load until start is re-asserted.
- Restart: second full load after done_ack -> identical address sequence 0..17 and two kernel_done pulses.
